// File: rtl/intmul_pkg.sv
// Shared constants and width helpers for the pipelined NTT integer multiplier.
package intmul_pkg;
  localparam int KYBER_Q   = 3329;
  localparam int DEF_W     = 12;
  localparam int DEF_LANES = 2;
  localparam int DEF_LAT   = 3;
  localparam int DEF_TAG_W = 8;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction
endpackage

// File: rtl/intmul_lane.sv
// One W x W multiplier lane, unsigned or two's-complement selected per operation.
module intmul_lane
  import intmul_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic             i_signed,
  input  logic [W-1:0]     i_a,
  input  logic [W-1:0]     i_b,
  output logic [2*W-1:0]   o_p
);
  localparam int PW = prod_w(W);

  logic signed [PW-1:0] w_a_ext;
  logic signed [PW-1:0] w_b_ext;
  (* use_dsp = "yes" *) logic signed [PW-1:0] w_prod;

  // Extending to the full product width first makes the truncated product exact in both modes.
  assign w_a_ext = {{W{i_signed & i_a[W-1]}}, i_a};
  assign w_b_ext = {{W{i_signed & i_b[W-1]}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;
  assign o_p     = w_prod;
endmodule

// File: rtl/intmul_pipe.sv
// Multi-lane pipelined multiplier with tag sideband and valid/ready backpressure.
module intmul_pipe
  import intmul_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int LANES = DEF_LANES,
  parameter int LAT   = DEF_LAT,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*W-1:0]     in_a,
  input  logic [LANES*W-1:0]     in_b,
  input  logic                   in_signed,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*2*W-1:0]   out_p,
  output logic [TAG_W-1:0]       out_tag
);
  localparam int PW = prod_w(W);

  logic [LANES*PW-1:0] w_prod;
  logic [LAT-1:0]      w_adv;
  logic                w_chain;

  logic [LAT-1:0]      r_vld;
  logic [LANES*PW-1:0] r_prod [LAT];
  logic [TAG_W-1:0]    r_tag  [LAT];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    intmul_lane #(.W(W)) u_lane (
      .i_signed (in_signed),
      .i_a      (in_a[i*W +: W]),
      .i_b      (in_b[i*W +: W]),
      .o_p      (w_prod[i*PW +: PW])
    );
  end

  // A stage may move when it is empty or everything below it can move.
  always_comb begin
    w_adv   = '0;
    w_chain = out_ready;
    for (int s = LAT - 1; s >= 0; s--) begin
      w_chain  = w_chain | ~r_vld[s];
      w_adv[s] = w_chain;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      for (int s = 0; s < LAT; s++) begin
        r_prod[s] <= '0;
        r_tag[s]  <= '0;
      end
    end else begin
      // s0: product formation
      if (w_adv[0]) r_vld[0] <= in_valid;
      if (w_adv[0] && in_valid) begin
        r_prod[0] <= w_prod;
        r_tag[0]  <= in_tag;
      end
      // s1..s(LAT-1): plain retiming registers
      for (int s = 1; s < LAT; s++) begin
        if (w_adv[s]) r_vld[s] <= r_vld[s-1];
        if (w_adv[s] && r_vld[s-1]) begin
          r_prod[s] <= r_prod[s-1];
          r_tag[s]  <= r_tag[s-1];
        end
      end
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_vld[LAT-1];
  assign out_p     = r_prod[LAT-1];
  assign out_tag   = r_tag[LAT-1];
endmodule

// File: tb/tb_intmul_pipe.sv
// Randomized and directed bench for intmul_pipe against an arithmetic reference model.
module tb_intmul_pipe;
  import intmul_pkg::*;

  localparam int W     = DEF_W;
  localparam int LANES = DEF_LANES;
  localparam int LAT   = DEF_LAT;
  localparam int TAG_W = DEF_TAG_W;
  localparam int PW    = 2 * W;
  localparam int AW    = LANES * W;
  localparam int OW    = LANES * PW;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [AW-1:0]    in_a = '0;
  logic [AW-1:0]    in_b = '0;
  logic             in_signed = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OW-1:0]    out_p;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  logic [OW-1:0]    exp_p [$];
  logic [TAG_W-1:0] exp_t [$];

  intmul_pipe #(.W(W), .LANES(LANES), .LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  // Reference: interpret each lane as an integer and multiply with plain arithmetic.
  function automatic logic [OW-1:0] model_p(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                            input logic s);
    logic [OW-1:0] r;
    longint x, y, p;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      x = longint'(a[i*W +: W]);
      y = longint'(b[i*W +: W]);
      if (s && a[i*W + W - 1]) x = x - (longint'(1) << W);
      if (s && b[i*W + W - 1]) y = y - (longint'(1) << W);
      p = x * y;
      r[i*PW +: PW] = p[PW-1:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_lane();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {{(W-1){1'b0}}, 1'b1};
      default: return r[W-1:0];
    endcase
  endfunction

  task automatic drive_rand();
    logic [31:0] t;
    t = $urandom();
    in_valid = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      in_a[i*W +: W] = rand_lane();
      in_b[i*W +: W] = rand_lane();
    end
    in_signed = 1'($urandom_range(0, 1));
    in_tag    = t[TAG_W-1:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    out_ready = 1'b0;
    drive_rand();
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_p !== '0) begin errors++; $display("FAIL reset_out_p: got %h expected 0", out_p); end
      checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_unsigned();
    int n;
    bit found;
    in_valid = 1'b1;
    in_a = '0; in_b = '0;
    in_a[0 +: W] = '1;
    in_b[0 +: W] = '1;
    in_a[W +: W] = W'(KYBER_Q - 1);
    in_b[W +: W] = W'(KYBER_Q - 1);
    in_signed = 1'b0;
    in_tag = 8'h5A;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n = 1; found = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (out_valid) begin found = 1; break; end
      tick(); n++;
    end
    checks++; if (!found || n != LAT) begin errors++; $display("FAIL single_latency: got %0d edges (found=%0d) expected %0d", n, found, LAT); end
    checks++; if (out_p !== 48'hA90000_FFE001) begin errors++; $display("FAIL single_out_p: got %h expected a90000ffe001", out_p); end
    checks++; if (out_tag !== 8'h5A) begin errors++; $display("FAIL single_out_tag: got %h expected 5a", out_tag); end
    tick();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_signed();
    int n;
    bit found;
    in_valid = 1'b1;
    in_a = {12'hFFF, 12'h800};
    in_b = {12'h005, 12'h800};
    in_signed = 1'b1;
    in_tag = 8'h3C;
    out_ready = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    n = 1; found = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (out_valid) begin found = 1; break; end
      tick(); n++;
    end
    checks++; if (!found || n != LAT) begin errors++; $display("FAIL signed_latency: got %0d edges (found=%0d) expected %0d", n, found, LAT); end
    checks++; if (out_p !== 48'hFFFFFB_400000) begin errors++; $display("FAIL signed_out_p: got %h expected fffffb400000", out_p); end
    checks++; if (out_tag !== 8'h3C) begin errors++; $display("FAIL signed_out_tag: got %h expected 3c", out_tag); end
    tick();
  endtask

  task automatic test_streaming();
    int got;
    bit exp_v;
    got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 + LAT + 2; cyc++) begin
      if (cyc < 100) drive_rand(); else in_valid = 1'b0;
      #1;
      if (cyc < 100) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready cyc %0d: got %b expected 1", cyc, in_ready); end
      end
      exp_v = (cyc >= LAT) && (cyc <= 99 + LAT);
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL stream_out_valid cyc %0d: got %b expected %b", cyc, out_valid, exp_v); end
      if (in_valid && in_ready) begin
        exp_p.push_back(model_p(in_a, in_b, in_signed));
        exp_t.push_back(in_tag);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_p.size() == 0) begin
          errors++; $display("FAIL stream_extra_output: got %h expected none", out_p);
        end else begin
          if (out_p !== exp_p[0] || out_tag !== exp_t[0]) begin
            errors++; $display("FAIL stream_data: got %h/%h expected %h/%h", out_p, out_tag, exp_p[0], exp_t[0]);
          end
          void'(exp_p.pop_front()); void'(exp_t.pop_front());
          got++;
        end
      end
      tick();
    end
    checks++; if (got != 100) begin errors++; $display("FAIL stream_count: got %0d expected 100", got); end
    exp_p.delete(); exp_t.delete();
  endtask

  task automatic test_backpressure();
    logic [OW-1:0]    held_p;
    logic [TAG_W-1:0] held_t;
    int got;
    bit exp_r;
    held_p = '0; held_t = '0; got = 0;
    out_ready = 1'b0;
    drive_rand();
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      exp_r = (cyc < LAT);
      checks++; if (in_ready !== exp_r) begin errors++; $display("FAIL bp_in_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_r); end
      if (cyc == LAT) begin
        held_p = out_p; held_t = out_tag;
      end
      if (cyc >= LAT) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc %0d: got %b expected 1", cyc, out_valid); end
        checks++; if (out_p !== held_p || out_tag !== held_t) begin errors++; $display("FAIL bp_stable cyc %0d: got %h/%h expected %h/%h", cyc, out_p, out_tag, held_p, held_t); end
      end
      if (in_valid && in_ready) begin
        exp_p.push_back(model_p(in_a, in_b, in_signed));
        exp_t.push_back(in_tag);
        tick();
        drive_rand();
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (out_valid) begin
        checks++;
        if (exp_p.size() == 0) begin
          errors++; $display("FAIL bp_extra_output: got %h expected none", out_p);
        end else begin
          if (out_p !== exp_p[0] || out_tag !== exp_t[0]) begin
            errors++; $display("FAIL bp_data: got %h/%h expected %h/%h", out_p, out_tag, exp_p[0], exp_t[0]);
          end
          void'(exp_p.pop_front()); void'(exp_t.pop_front());
          got++;
        end
      end
      tick();
    end
    checks++; if (got != LAT) begin errors++; $display("FAIL bp_count: got %0d expected %0d", got, LAT); end
    exp_p.delete(); exp_t.delete();
  endtask

  task automatic test_bubble_collapse();
    int got;
    got = 0;
    out_ready = 1'b0;
    drive_rand();
    #1;
    exp_p.push_back(model_p(in_a, in_b, in_signed));
    exp_t.push_back(in_tag);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bubble_s2_valid: got %b expected 1", out_valid); end
    for (int k = 0; k < 3; k++) begin
      drive_rand();
      #1;
      checks++;
      if (in_ready !== (k < 2)) begin errors++; $display("FAIL bubble_in_ready op %0d: got %b expected %b", k, in_ready, (k < 2)); end
      if (in_ready) begin
        exp_p.push_back(model_p(in_a, in_b, in_signed));
        exp_t.push_back(in_tag);
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (out_valid) begin
        checks++;
        if (exp_p.size() == 0) begin
          errors++; $display("FAIL bubble_extra_output: got %h expected none", out_p);
        end else begin
          if (out_p !== exp_p[0] || out_tag !== exp_t[0]) begin
            errors++; $display("FAIL bubble_data: got %h/%h expected %h/%h", out_p, out_tag, exp_p[0], exp_t[0]);
          end
          void'(exp_p.pop_front()); void'(exp_t.pop_front());
          got++;
        end
      end
      tick();
    end
    checks++; if (got != 3) begin errors++; $display("FAIL bubble_count: got %0d expected 3", got); end
    exp_p.delete(); exp_t.delete();
  endtask

  task automatic test_async_reset();
    logic [OW-1:0] want;
    int n;
    bit found;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_rand();
      #1;
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %b expected 1", out_valid); end
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_p !== '0 || out_tag !== '0) begin errors++; $display("FAIL arst_data: got %h/%h expected 0/0", out_p, out_tag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %b expected 1", in_ready); end
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    for (int k = 0; k < LAT + 1; k++) begin
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_no_replay cyc %0d: got %b expected 0", k, out_valid); end
      tick();
    end
    drive_rand();
    in_tag = 8'hC3;
    want = model_p(in_a, in_b, in_signed);
    #1;
    tick();
    in_valid = 1'b0;
    n = 1; found = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (out_valid) begin found = 1; break; end
      tick(); n++;
    end
    checks++; if (!found || n != LAT) begin errors++; $display("FAIL arst_post_latency: got %0d edges (found=%0d) expected %0d", n, found, LAT); end
    checks++; if (out_p !== want || out_tag !== 8'hC3) begin errors++; $display("FAIL arst_post_data: got %h/%h expected %h/c3", out_p, out_tag, want); end
    tick();
  endtask

  task automatic test_random_flow();
    bit pending, prev_stall;
    logic [OW-1:0]    prev_p;
    logic [TAG_W-1:0] prev_t;
    pending = 0; prev_stall = 0; prev_p = '0; prev_t = '0;
    for (int cyc = 0; cyc < 400 + LAT + 4; cyc++) begin
      if (cyc >= 400) begin
        if (!pending) in_valid = 1'b0;
        out_ready = 1'b1;
      end else begin
        if (!pending) begin
          if ($urandom_range(0, 9) < 7) drive_rand(); else in_valid = 1'b0;
        end
        out_ready = ($urandom_range(0, 9) < 6);
      end
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_p !== prev_p || out_tag !== prev_t) begin
          errors++; $display("FAIL rand_stable cyc %0d: got %b %h/%h expected 1 %h/%h", cyc, out_valid, out_p, out_tag, prev_p, prev_t);
        end
      end
      if (in_valid && in_ready) begin
        exp_p.push_back(model_p(in_a, in_b, in_signed));
        exp_t.push_back(in_tag);
      end
      pending = in_valid && !in_ready;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_p.size() == 0) begin
          errors++; $display("FAIL rand_extra_output: got %h expected none", out_p);
        end else begin
          if (out_p !== exp_p[0] || out_tag !== exp_t[0]) begin
            errors++; $display("FAIL rand_data cyc %0d: got %h/%h expected %h/%h", cyc, out_p, out_tag, exp_p[0], exp_t[0]);
          end
          void'(exp_p.pop_front()); void'(exp_t.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_p = out_p;
      prev_t = out_tag;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (exp_p.size() != 0) begin errors++; $display("FAIL rand_leftover: got %0d pending expected 0", exp_p.size()); end
    exp_p.delete(); exp_t.delete();
  endtask

  initial begin
    test_reset();
    test_single_unsigned();
    test_signed();
    test_streaming();
    test_backpressure();
    test_bubble_collapse();
    test_async_reset();
    test_random_flow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/intmul_pipe.md
Name: intmul_pipe

Overview:
- Parametrised, pipelined, multi-lane successor to the 12x12 combinational integer multiplier used by the NTT butterfly datapath.
- Computes LANES independent W x W products per transaction, unsigned or two's-complement signed, selected per transaction.
- Carries a sideband tag through a LAT-deep valid/ready pipeline with full backpressure.
- Sits between the butterfly operand mux and the modular-reduction unit.

Parameters:
- W, 12, operand width per lane (>=2).
- LANES, 2, number of parallel multiplier lanes (>=1).
- LAT, 3, pipeline depth in register stages (>=1).
- TAG_W, 8, sideband tag width (>=1).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  transaction offered.
- in_ready  out  1  pipeline can accept this cycle.
- in_a  in  LANES*W  lane i operand at bits [i*W +: W].
- in_b  in  LANES*W  same packing as in_a.
- in_signed  in  1  1: signed operands; 0: unsigned.
- in_tag  in  TAG_W  opaque sideband.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_p  out  LANES*2W  lane i product at bits [i*2W +: 2W].
- out_tag  out  TAG_W  tag of the transaction on out_p.

Behaviour:
- One clock, reset is asynchronous and active-low; clock port clk, reset port reset_n.
- Reset: all stage valid bits, data and tag registers clear to 0 immediately on reset_n low, with no clock required. Outputs during reset: out_valid=0, out_p=0, out_tag=0, in_ready=1.
- Reset mid-operation: in-flight transactions are discarded, not replayed. The first cycle after release behaves as an empty pipe.
- Pipeline: stages s0..s(LAT-1), each holding valid bit v[s], LANES products and tag. s(LAT-1) drives the outputs directly, with no combinational path from in_a/in_b to out_p.
- Advance rule: adv[LAT-1] = !v[LAT-1] | out_ready; adv[s] = !v[s] | adv[s+1]. in_ready = adv[0], combinational from out_ready (no skid buffer).
- Transfers:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - On adv[s], stage s loads stage s-1 (s0 loads the input), and v[s] takes the upstream valid.
  - Stages with adv[s]=0 hold all contents.
- Bubble collapse: an empty stage always advances, so a stalled output does not block filling of empty upstream stages.
- Latency: with out_ready held 1, a transaction accepted at edge n appears with out_valid=1 after edge n+LAT-1. Throughput is 1 transaction/cycle sustained.
- Arithmetic:
  - Unsigned: out_p lane = zero-extended product, exact in 2W bits.
  - Signed: operands are sign-extended; the product is two's complement in 2W bits. (-2^(W-1))^2 = 2^(2W-2) fits exactly.
- Product formation happens in s0. Stages s1..s(LAT-1) are plain registers so synthesis can retime into DSP pipeline registers. Each lane's multiplier carries the use_dsp attribute.
- in_signed is captured with the operands and is not carried to the outputs.
- Simultaneous in and out transfer when full: allowed, with no loss and no duplication.
- Protocol rules:
  - out_p/out_tag stable while out_valid & !out_ready.
  - in_* may change freely when in_valid=0.
- No X propagation: in_a/in_b are ignored when in_valid=0 (stage loads only if upstream valid, else data regs hold).

Decomposition:
- Package intmul_pkg: KYBER_Q=3329, default W=12, default LANES=2, default LAT=3, default TAG_W=8, and function prod_w(w)=2*w.
- Sub-module intmul_lane: combinational W x W signed/unsigned multiply with a use_dsp-attributed product wire. It is instantiated LANES times in s0.
- Valid/advance chain and stage registers live in intmul_pipe.

Test Plan:
- Reset then single op (W=12, LANES=2, LAT=3): lane0 4095*4095, lane1 3328*3328, unsigned, tag 0x5A, out_ready=1 -> out_valid after 3 edges; out_p lanes 0xFFE001 and 0xA90000 (11075584); tag 0x5A.
- Signed mode: lane0 0x800*0x800, lane1 0xFFF*0x005 -> lane0 0x400000, lane1 0xFFFFFB.
- Streaming: 100 back-to-back random ops with out_ready=1 -> in_ready constant 1, out_valid continuous from cycle 3, results and tags match a golden model in order.
- Backpressure: fill the pipe, hold out_ready=0 for 5 cycles -> in_ready=0 after 3 accepts, out_p/out_tag stable; release -> all 3 results delivered in order, none lost or duplicated.
- Bubble collapse: out_ready=0 with only s2 valid, offer 2 new ops -> both accepted (in_ready=1 twice), third refused.
- Async reset mid-stream: assert reset_n low between edges with 3 valid ops -> out_valid=0 immediately. After release, first output appears only from ops accepted post-reset.
